// File: rtl/eq2_resp_checker.sv
// Response checker for the 2-bit equality comparator: tallies pass/fail, captures first mismatch.
// Optional MISR signature output enabled by defining EQ2_CHK_SIG_EN.
module eq2_resp_checker #(
  parameter int W     = 2,
  parameter int N_VEC = 7,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          aeqb,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] vec_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          fail_seen,
  output logic [CW-1:0] fail_idx,
  output logic [W-1:0]  fail_a,
  output logic [W-1:0]  fail_b
`ifdef EQ2_CHK_SIG_EN
  ,
  output logic [15:0]   sig
`endif
);

  // Run length is tracked separately so a narrow vec_cnt may wrap without ending the run early.
  localparam int AW = (N_VEC < 2) ? 1 : $clog2(N_VEC + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc_cnt;
  logic            accept;
  logic            mismatch;
  logic            last_vec;
  logic [CW-1:0]   err_next;

  assign accept   = (state == RUN) && in_valid && !start;
  assign mismatch = aeqb != (a == b);
  assign last_vec = acc_cnt == AW'(N_VEC - 1);
  assign err_next = (mismatch && (err_cnt != {CW{1'b1}})) ? err_cnt + 1'b1 : err_cnt;

`ifdef EQ2_CHK_SIG_EN
  // Galois MISR for x^16+x^12+x^5+1; response bits fold into the low end.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ d;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
`ifdef EQ2_CHK_SIG_EN
      sig       <= 16'hFFFF;
`endif
    end else if (start) begin
      state     <= RUN;
      acc_cnt   <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
`ifdef EQ2_CHK_SIG_EN
      sig       <= 16'hFFFF;
`endif
    end else if (accept) begin
      vec_cnt <= vec_cnt + 1'b1;
      err_cnt <= err_next;
      acc_cnt <= acc_cnt + 1'b1;
      if (mismatch && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_idx  <= vec_cnt;
        fail_a    <= a;
        fail_b    <= b;
      end
`ifdef EQ2_CHK_SIG_EN
      sig <= misr_step(sig, 16'({a, b, aeqb}));
`endif
      if (last_vec) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_eq2_resp_checker.sv
// Scoreboard bench for eq2_resp_checker: default build plus a CW=3/N_VEC=10 instance.
// Signature checks are compiled in when EQ2_CHK_SIG_EN is defined.
module tb_eq2_resp_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, in_valid, aeqb;
  logic [1:0]  a, b;
  logic        busy, done, pass, fail_seen;
  logic [15:0] vec_cnt, err_cnt, fail_idx;
  logic [1:0]  fail_a, fail_b;
  logic [15:0] sig;

  logic        s_start, s_valid, s_aeqb;
  logic [1:0]  s_a, s_b;
  logic        s_busy, s_done, s_pass, s_fail_seen;
  logic [2:0]  s_vec, s_err, s_fail_idx;
  logic [1:0]  s_fail_a, s_fail_b;
  logic [15:0] s_sig;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eq2_resp_checker #(.W(2), .N_VEC(7), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .aeqb(aeqb), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .fail_seen(fail_seen),
    .fail_idx(fail_idx), .fail_a(fail_a), .fail_b(fail_b)
`ifdef EQ2_CHK_SIG_EN
    , .sig(sig)
`endif
  );

  eq2_resp_checker #(.W(2), .N_VEC(10), .CW(3)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .in_valid(s_valid),
    .a(s_a), .b(s_b), .aeqb(s_aeqb), .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_cnt(s_vec), .err_cnt(s_err), .fail_seen(s_fail_seen),
    .fail_idx(s_fail_idx), .fail_a(s_fail_a), .fail_b(s_fail_b)
`ifdef EQ2_CHK_SIG_EN
    , .sig(s_sig)
`endif
  );

`ifndef EQ2_CHK_SIG_EN
  assign sig   = 16'hFFFF;
  assign s_sig = 16'hFFFF;
`endif

  typedef struct {
    logic        busy, done, pass, fs;
    logic [15:0] vec, err, fidx, sig;
    logic [1:0]  fa, fb;
  } exp_t;

  exp_t sb[$];

  int          m_state;
  int          m_acc;
  logic        m_pass, m_fs;
  logic [15:0] m_vec, m_err, m_fidx, m_sig;
  logic [1:0]  m_fa, m_fb;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    return n ^ {11'b0, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_acc = 0; m_pass = 0; m_fs = 0;
    m_vec = 0; m_err = 0; m_fidx = 0; m_fa = 0; m_fb = 0;
    m_sig = 16'hFFFF;
  endtask

  task automatic model_step(input logic st, input logic v, input logic [1:0] aa,
                            input logic [1:0] bb, input logic q);
    logic mis;
    if (st) begin
      model_reset();
      m_state = 1;
    end else if (m_state == 1 && v) begin
      mis = (q != (aa == bb));
      if (mis && !m_fs) begin
        m_fs = 1; m_fidx = m_vec; m_fa = aa; m_fb = bb;
      end
      if (mis && m_err != 16'hFFFF) m_err = m_err + 1;
      m_vec = m_vec + 1;
      m_sig = misr(m_sig, {aa, bb, q});
      m_acc++;
      if (m_acc == 7) begin
        m_state = 2;
        m_pass = (m_err == 0);
      end
    end
  endtask

  task automatic compare_expected();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    checkOutput("busy", busy, e.busy);
    checkOutput("done", done, e.done);
    checkOutput("pass", pass, e.pass);
    checkOutput("vec_cnt", vec_cnt, e.vec);
    checkOutput("err_cnt", err_cnt, e.err);
    checkOutput("fail_seen", fail_seen, e.fs);
    checkOutput("fail_idx", fail_idx, e.fidx);
    checkOutput("fail_a", fail_a, e.fa);
    checkOutput("fail_b", fail_b, e.fb);
`ifdef EQ2_CHK_SIG_EN
    checkOutput("sig", sig, e.sig);
`endif
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic [1:0] aa,
                               input logic [1:0] bb, input logic q);
    exp_t e;
    @(negedge clk);
    start = st; in_valid = v; a = aa; b = bb; aeqb = q;
    @(posedge clk);
    model_step(st, v, aa, bb, q);
    e.busy = (m_state == 1); e.done = (m_state == 2); e.pass = m_pass; e.fs = m_fs;
    e.vec = m_vec; e.err = m_err; e.fidx = m_fidx; e.sig = m_sig;
    e.fa = m_fa; e.fb = m_fb;
    sb.push_back(e);
    #1;
    compare_expected();
  endtask

  logic [1:0] va[7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [1:0] vb[7] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};

  task automatic run_vectors(input int n, input logic [6:0] force_one, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, va[i], vb[i], force_one[i] ? 1'b1 : (va[i] == vb[i]));
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] s_model;
    reset_n = 1'b0;
    start = 0; in_valid = 0; a = 0; b = 0; aeqb = 0;
    s_start = 0; s_valid = 0; s_a = 0; s_b = 0; s_aeqb = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_vec", vec_cnt, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_fail_seen", fail_seen, 0);
`ifdef EQ2_CHK_SIG_EN
    checkOutput("rst_sig", sig, 16'hFFFF);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] idle valids then good run");
    applyStimulus(1'b0, 1'b1, 2'd1, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd2, 1'b1);
    run_vectors(7, 7'b0, 0);
    applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 2'd1, 1'b1);

    $display("[TB] failing run, aeqb stuck on vectors 2 and 5");
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    run_vectors(7, 7'b0010010, 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    $display("[TB] gapped run");
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    run_vectors(7, 7'b0, 2);

    $display("[TB] restart mid failing run");
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    run_vectors(4, 7'b0010010, 0);
    applyStimulus(1'b1, 1'b1, 2'd1, 2'd0, 1'b1);
    run_vectors(7, 7'b0, 0);

    $display("[TB] random run");
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic [1:0] ra, rb;
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), ra, rb,
                    (ra == rb) ^ ($urandom_range(0, 3) == 0));
    end

    $display("[TB] async reset mid run");
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    run_vectors(3, 7'b0000010, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_vec", vec_cnt, 0);
    checkOutput("arst_err", err_cnt, 0);
    checkOutput("arst_fail_seen", fail_seen, 0);
    model_reset();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'd2, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 2'd1, 1'b1);

    $display("[TB] narrow counter instance");
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s_busy_start", s_busy, 1);
    @(negedge clk);
    s_start = 1'b0;
    s_model = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_a = 2'(i);
      s_b = 2'(i >> 1);
      s_aeqb = !(s_a == s_b);
      s_model = misr(s_model, {s_a, s_b, s_aeqb});
      @(posedge clk);
      #1;
      checkOutput($sformatf("s_err_%0d", i), s_err, (i + 1 > 7) ? 7 : i + 1);
      checkOutput($sformatf("s_vec_%0d", i), s_vec, (i + 1) % 8);
      checkOutput($sformatf("s_done_%0d", i), s_done, (i == 9) ? 1 : 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("s_pass", s_pass, 0);
    checkOutput("s_fail_seen", s_fail_seen, 1);
    checkOutput("s_fail_idx", s_fail_idx, 0);
    checkOutput("s_busy_end", s_busy, 0);
`ifdef EQ2_CHK_SIG_EN
    checkOutput("s_sig", s_sig, s_model);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eq2_resp_checker.md
Name: eq2_resp_checker

Overview:
Synthesizable response checker for the 2-bit equality comparator (eq2). It sits on the receiving side of the comparator's test interface: it takes each applied operand pair plus the DUT's aeqb output, computes the expected result, and tallies pass/fail. It also captures the first mismatch and reports a verdict after a programmed number of vectors, so on-chip self-test needs no simulator.

Parameters:
W, 2, operand width of a/b (expected result is a==b over W bits)
N_VEC, 7, number of accepted vectors that completes a run (>=1)
CW, 16, width of vector and error counters

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  1-cycle pulse: clear results and begin a run
in_valid  input  1  a/b/aeqb hold a valid sample this cycle
a  input  W  operand 0 applied to DUT
b  input  W  operand 1 applied to DUT
aeqb  input  1  DUT response under check
busy  output  1  run in progress
done  output  1  run complete; held until next start
pass  output  1  done and zero errors
vec_cnt  output  CW  vectors accepted this run
err_cnt  output  CW  mismatches this run, saturating at all-ones
fail_seen  output  1  sticky: at least one mismatch this run
fail_idx  output  CW  vec_cnt value of first mismatch
fail_a  output  W  a of first mismatch
fail_b  output  W  b of first mismatch

Behaviour:
- Reset (reset_n=0, any time, asynchronous): state=IDLE; all outputs 0; takes effect immediately, including mid-run; no partial results retained.
- FSM states IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE/DONE --start--> RUN: same edge clears vec_cnt, err_cnt, fail_seen, fail_idx/a/b, pass.
- start while in RUN: restart; clears as above, stays RUN; in_valid that cycle is dropped.
- RUN, in_valid=1 (and no start): expected = (a==b); mismatch = (aeqb != expected).
  vec_cnt <= vec_cnt+1.
  On mismatch: err_cnt <= err_cnt+1, holding at 2^CW-1.
  On first mismatch (fail_seen=0): fail_seen<=1; fail_idx<=current vec_cnt (0-based); fail_a<=a; fail_b<=b. Later mismatches never overwrite the capture.
- RUN -> DONE on the edge that accepts vector N_VEC (vec_cnt becomes N_VEC). pass <= (err_cnt_next==0) on that edge.
- in_valid in IDLE or DONE: ignored, no counter change.
- All outputs registered; results visible 1 cycle after the sampling edge.
- aeqb is X/Z-free in synthesis; no tolerance window. The DUT must be combinational and settled at the sampling edge.

Optional Feature:
Macro EQ2_CHK_SIG_EN.
- Defined: adds output sig[15:0], a 16-bit MISR (x^16+x^12+x^5+1, Galois form). It clears to 16'hFFFF on start and on reset, and each accepted vector shifts once with {a,b,aeqb} XORed into the low bits. It freezes in DONE, giving a golden-signature compare for long runs.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with good DUT; vectors (00,00),(01,00),(01,11),(10,10),(10,00),(11,11),(11,01) with aeqb=1,0,0,1,0,1,0 -> done=1 the cycle after 7th, pass=1, vec_cnt=7, err_cnt=0, fail_seen=0.
- Same vectors with aeqb forced 1 on vectors 2 and 5 -> err_cnt=2, fail_seen=1, fail_idx=1, fail_a=01, fail_b=00, pass=0.
- in_valid gaps (valid every 3rd cycle) and in_valid pulses while IDLE/DONE -> vec_cnt counts only RUN valids, final 7; extra DONE valids leave counts unchanged.
- start asserted after vector 4 of a failing run -> counters and capture cleared, busy stays 1, a clean rerun of 7 vectors gives pass=1.
- reset_n dropped asynchronously mid-run (between edges) -> busy/done/counts 0 immediately; after release, outputs stay idle until start.
- CW=3 build, N_VEC=10, aeqb always inverted -> err_cnt saturates at 7, vec_cnt wraps (10 mod 8 = 2), done asserted after 10th vector; with EQ2_CHK_SIG_EN, sig matches the model's MISR value.
